// File: rtl/lut_corr_avg_if.sv
// Port bundle between the LUT correction outputs and the averaging block.
// Optional raw-sum outputs exist only when LUT_CORR_AVG_RAW_SUM_EN is defined.
interface lut_corr_avg_if #(
  parameter int DW    = 21,
  parameter int DLY_W = 8
`ifdef LUT_CORR_AVG_RAW_SUM_EN
  , parameter int SUM_W = 24
`endif
);
  logic                    trig;
  logic [DLY_W-1:0]        delay;
  logic                    lut_cond;
  logic signed [DW-1:0]    bpm1_i_in, bpm1_q_in, bpm2_i_in, bpm2_q_in;
  logic signed [DW-1:0]    bpm1_i_avg, bpm1_q_avg, bpm2_i_avg, bpm2_q_avg;
  logic                    avg_valid;
  logic                    busy;
  logic                    timeout;
  logic                    overrun;
`ifdef LUT_CORR_AVG_RAW_SUM_EN
  logic signed [SUM_W-1:0] bpm1_i_sum, bpm1_q_sum, bpm2_i_sum, bpm2_q_sum;
`endif

  modport master (
    output trig, delay, lut_cond, bpm1_i_in, bpm1_q_in, bpm2_i_in, bpm2_q_in,
    input  bpm1_i_avg, bpm1_q_avg, bpm2_i_avg, bpm2_q_avg,
    input  avg_valid, busy, timeout, overrun
`ifdef LUT_CORR_AVG_RAW_SUM_EN
    , input bpm1_i_sum, bpm1_q_sum, bpm2_i_sum, bpm2_q_sum
`endif
  );

  modport slave (
    input  trig, delay, lut_cond, bpm1_i_in, bpm1_q_in, bpm2_i_in, bpm2_q_in,
    output bpm1_i_avg, bpm1_q_avg, bpm2_i_avg, bpm2_q_avg,
    output avg_valid, busy, timeout, overrun
`ifdef LUT_CORR_AVG_RAW_SUM_EN
    , output bpm1_i_sum, bpm1_q_sum, bpm2_i_sum, bpm2_q_sum
`endif
  );
endinterface

// File: rtl/lut_corr_avg.sv
// Triggered, delayed 2^LOG2_N-sample average of the four BPM I/Q LUT outputs.
// Define LUT_CORR_AVG_RAW_SUM_EN to also expose the unrounded accumulator sums.
module lut_corr_avg #(
  parameter int DW      = 21,
  parameter int LOG2_N  = 3,
  parameter int DLY_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  lut_corr_avg_if.slave bus
);
  localparam int N  = 1 << LOG2_N;
  localparam int AW = DW + LOG2_N;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic signed [AW-1:0] HALF = AW'(N / 2);

  typedef enum logic [1:0] {IDLE, WAIT, ACCUM, DONE} state_t;

  state_t               state_reg, state_next;
  logic [DLY_W-1:0]     dly_cnt_reg;
  logic [LOG2_N-1:0]    smp_cnt_reg;
  logic [TW-1:0]        tc_reg;
  logic                 avg_valid_reg, timeout_reg, overrun_reg;
  logic                 start, accept, last_smp, abort;
  logic signed [DW-1:0] din [4];

  assign din[0] = bus.bpm1_i_in;
  assign din[1] = bus.bpm1_q_in;
  assign din[2] = bus.bpm2_i_in;
  assign din[3] = bus.bpm2_q_in;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // The final sample takes priority over a timeout landing on the same cycle.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    accept     = 1'b0;
    last_smp   = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.trig) begin
          start      = 1'b1;
          state_next = (bus.delay == '0) ? ACCUM : WAIT;
        end
      end
      WAIT: begin
        if (dly_cnt_reg == DLY_W'(1)) state_next = ACCUM;
      end
      ACCUM: begin
        accept   = bus.lut_cond;
        last_smp = bus.lut_cond && (smp_cnt_reg == LOG2_N'(N - 1));
        if (last_smp) begin
          state_next = DONE;
        end else if (tc_reg == TW'(TIMEOUT - 1)) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_cnt_reg   <= '0;
      smp_cnt_reg   <= '0;
      tc_reg        <= '0;
      avg_valid_reg <= 1'b0;
      timeout_reg   <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      avg_valid_reg <= (state_reg == DONE);
      timeout_reg   <= abort;
      if (bus.trig && (state_reg != IDLE)) overrun_reg <= 1'b1;
      if (start) begin
        dly_cnt_reg <= bus.delay;
        smp_cnt_reg <= '0;
        tc_reg      <= '0;
      end else if (state_reg == WAIT) begin
        dly_cnt_reg <= dly_cnt_reg - DLY_W'(1);
      end else if (state_reg == ACCUM) begin
        tc_reg <= tc_reg + TW'(1);
        if (accept) smp_cnt_reg <= smp_cnt_reg + LOG2_N'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      logic signed [AW-1:0] acc_reg;
      logic signed [DW-1:0] avg_reg;

      // Bias by half an LSB then arithmetic shift: rounds half toward +inf.
      always_ff @(posedge clk) begin
        if (rst) begin
          acc_reg <= '0;
          avg_reg <= '0;
        end else begin
          if (start)       acc_reg <= '0;
          else if (accept) acc_reg <= acc_reg + {{LOG2_N{din[gi][DW-1]}}, din[gi]};
          if (state_reg == DONE) avg_reg <= DW'((acc_reg + HALF) >>> LOG2_N);
        end
      end
`ifdef LUT_CORR_AVG_RAW_SUM_EN
      logic signed [AW-1:0] sum_reg;
      always_ff @(posedge clk) begin
        if (rst)                    sum_reg <= '0;
        else if (state_reg == DONE) sum_reg <= acc_reg;
      end
`endif
    end
  endgenerate

  assign bus.bpm1_i_avg = g_ch[0].avg_reg;
  assign bus.bpm1_q_avg = g_ch[1].avg_reg;
  assign bus.bpm2_i_avg = g_ch[2].avg_reg;
  assign bus.bpm2_q_avg = g_ch[3].avg_reg;
`ifdef LUT_CORR_AVG_RAW_SUM_EN
  assign bus.bpm1_i_sum = g_ch[0].sum_reg;
  assign bus.bpm1_q_sum = g_ch[1].sum_reg;
  assign bus.bpm2_i_sum = g_ch[2].sum_reg;
  assign bus.bpm2_q_sum = g_ch[3].sum_reg;
`endif
  assign bus.avg_valid = avg_valid_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.timeout   = timeout_reg;
  assign bus.overrun   = overrun_reg;
endmodule

// File: tb/tb_lut_corr_avg.sv
// Self-checking bench for lut_corr_avg: transaction-level reference model plus
// directed literal checks; raw sums are checked when LUT_CORR_AVG_RAW_SUM_EN is defined.
module tb_lut_corr_avg;
  localparam int DW      = 21;
  localparam int LOG2_N  = 3;
  localparam int DLY_W   = 8;
  localparam int TIMEOUT = 64;
  localparam int N       = 1 << LOG2_N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lut_corr_avg_if #(
    .DW(DW), .DLY_W(DLY_W)
`ifdef LUT_CORR_AVG_RAW_SUM_EN
    , .SUM_W(DW + LOG2_N)
`endif
  ) bus ();

  lut_corr_avg #(.DW(DW), .LOG2_N(LOG2_N), .DLY_W(DLY_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time is counted from the trigger edge; the accumulation
  // window opens after `delay` cycles and lasts at most TIMEOUT cycles.
  bit     m_active, m_fin;
  int     m_c, m_d, m_cnt;
  longint m_sum [4];
  longint exp_avg [4];
  longint exp_sum [4];
  bit     exp_valid, exp_busy, exp_to, exp_ovr;

  function automatic longint rnd_avg(input longint s);
    longint q;
    q = s + N / 2;
    if (q >= 0) return q / N;
    return -((-q + N - 1) / N);
  endfunction

  always @(posedge clk) begin
    longint cur [4];
    cur[0] = longint'(bus.bpm1_i_in);
    cur[1] = longint'(bus.bpm1_q_in);
    cur[2] = longint'(bus.bpm2_i_in);
    cur[3] = longint'(bus.bpm2_q_in);
    exp_valid = 1'b0;
    exp_to    = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_fin    = 1'b0;
      exp_ovr  = 1'b0;
      for (int i = 0; i < 4; i++) begin
        exp_avg[i] = 0;
        exp_sum[i] = 0;
      end
    end else if (!m_active) begin
      if (bus.trig) begin
        m_active = 1'b1;
        m_fin    = 1'b0;
        m_d      = int'(bus.delay);
        m_c      = 0;
        m_cnt    = 0;
        for (int i = 0; i < 4; i++) m_sum[i] = 0;
      end
    end else begin
      if (bus.trig) exp_ovr = 1'b1;
      if (m_fin) begin
        for (int i = 0; i < 4; i++) begin
          exp_avg[i] = rnd_avg(m_sum[i]);
          exp_sum[i] = m_sum[i];
        end
        exp_valid = 1'b1;
        m_active  = 1'b0;
      end else if (m_c >= m_d) begin
        if (bus.lut_cond) begin
          for (int i = 0; i < 4; i++) m_sum[i] += cur[i];
          m_cnt++;
          if (m_cnt == N) m_fin = 1'b1;
        end
        if (!m_fin && (m_c - m_d == TIMEOUT - 1)) begin
          m_active = 1'b0;
          exp_to   = 1'b1;
        end
      end
      m_c++;
    end
    exp_busy = m_active;
  end

  task automatic chk(input string name, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic compare_all();
    chk("avg_valid", longint'(bus.avg_valid), longint'(exp_valid));
    chk("busy", longint'(bus.busy), longint'(exp_busy));
    chk("timeout", longint'(bus.timeout), longint'(exp_to));
    chk("overrun", longint'(bus.overrun), longint'(exp_ovr));
    chk("bpm1_i_avg", longint'(bus.bpm1_i_avg), exp_avg[0]);
    chk("bpm1_q_avg", longint'(bus.bpm1_q_avg), exp_avg[1]);
    chk("bpm2_i_avg", longint'(bus.bpm2_i_avg), exp_avg[2]);
    chk("bpm2_q_avg", longint'(bus.bpm2_q_avg), exp_avg[3]);
`ifdef LUT_CORR_AVG_RAW_SUM_EN
    chk("bpm1_i_sum", longint'(bus.bpm1_i_sum), exp_sum[0]);
    chk("bpm1_q_sum", longint'(bus.bpm1_q_sum), exp_sum[1]);
    chk("bpm2_i_sum", longint'(bus.bpm2_i_sum), exp_sum[2]);
    chk("bpm2_q_sum", longint'(bus.bpm2_q_sum), exp_sum[3]);
`endif
    if (bus.avg_valid)
      $display("[TB] %0t avg_valid %0d %0d %0d %0d", $time, bus.bpm1_i_avg,
               bus.bpm1_q_avg, bus.bpm2_i_avg, bus.bpm2_q_avg);
    if (bus.timeout) $display("[TB] %0t timeout abort", $time);
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drv(input bit tg, input int dl, input bit lc,
                     input int a, input int b, input int c, input int d);
    bus.trig      = tg;
    bus.delay     = DLY_W'(dl);
    bus.lut_cond  = lc;
    bus.bpm1_i_in = DW'(a);
    bus.bpm1_q_in = DW'(b);
    bus.bpm2_i_in = DW'(c);
    bus.bpm2_q_in = DW'(d);
  endtask

  task automatic wait_evt(input bit want_to, input int lim, input string name);
    bit seen;
    seen = 1'b0;
    bus.trig = 1'b0;
    for (int k = 0; k < lim && !seen; k++) begin
      cyc();
      seen = want_to ? bus.timeout : bus.avg_valid;
    end
    chk(name, longint'(seen), 1);
  endtask

  function automatic int rv();
    return int'($urandom_range(0, 2097151)) - 1048576;
  endfunction

  initial begin
    int r [8];
    int ext [2];
    bit seen;
    int to_c;
    r   = '{2, 2, 2, 2, 1, 1, 1, 1};
    ext = '{1048575, -1048576};

    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_avg", longint'(bus.bpm1_i_avg), 0);
    rst = 1'b0;
    cyc();

    // Constant inputs, no delay
    drv(1, 0, 1, 1000, -1000, 5, -5);
    cyc();
    wait_evt(0, 30, "const_valid_seen");
    chk("const_i1", longint'(bus.bpm1_i_avg), 1000);
    chk("const_q1", longint'(bus.bpm1_q_avg), -1000);
    chk("const_i2", longint'(bus.bpm2_i_avg), 5);
    chk("const_q2", longint'(bus.bpm2_q_avg), -5);
    chk("model_const_q1", exp_avg[1], -1000);
    chk("const_busy_low", longint'(bus.busy), 0);
    cyc();
    chk("const_valid_one_cycle", longint'(bus.avg_valid), 0);

    // Rounding half toward +inf
    drv(1, 0, 0, 0, 0, 0, 0);
    cyc();
    for (int k = 0; k < 8; k++) begin
      drv(0, 0, 1, r[k], -r[k], 0, 0);
      cyc();
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    wait_evt(0, 10, "round_valid_seen");
    chk("round_i", longint'(bus.bpm1_i_avg), 2);
    chk("round_q", longint'(bus.bpm1_q_avg), -1);
    chk("model_round_q", exp_avg[1], -1);
`ifdef LUT_CORR_AVG_RAW_SUM_EN
    chk("round_sum_i", longint'(bus.bpm1_i_sum), 12);
    chk("round_sum_q", longint'(bus.bpm1_q_sum), -12);
`endif

    // Full-scale extremes must not wrap
    for (int e = 0; e < 2; e++) begin
      drv(1, 0, 1, ext[e], ext[e], ext[e], ext[e]);
      cyc();
      wait_evt(0, 30, "extreme_valid_seen");
      chk("extreme_i1", longint'(bus.bpm1_i_avg), longint'(ext[e]));
      chk("extreme_q2", longint'(bus.bpm2_q_avg), longint'(ext[e]));
    end

    // delay=5, lut_cond toggling; WAIT-period values must not leak in
    drv(1, 5, 0, 0, 0, 0, 0);
    cyc();
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (c < 5) drv(0, 0, (c % 2) == 0, 777777, 777777, 777777, 777777);
      else       drv(0, 0, (c % 2) == 0, 64, -64, 3, -3);
      cyc();
      seen = bus.avg_valid;
      if (seen) chk("gap_valid_cycle", c, 21);
    end
    chk("gap_valid_seen", longint'(seen), 1);
    chk("gap_i1", longint'(bus.bpm1_i_avg), 64);
    chk("gap_q1", longint'(bus.bpm1_q_avg), -64);
    chk("gap_i2", longint'(bus.bpm2_i_avg), 3);

    // Timeout with only three qualified samples
    drv(1, 0, 0, 9999, 9999, 9999, 9999);
    cyc();
    seen = 1'b0;
    to_c = -1;
    for (int c = 0; c < 100 && !seen; c++) begin
      drv(0, 0, (c == 3) || (c == 10) || (c == 20), 9999, 9999, 9999, 9999);
      cyc();
      seen = bus.timeout;
      if (seen) to_c = c;
    end
    chk("timeout_seen", longint'(seen), 1);
    chk("timeout_cycle", to_c, TIMEOUT - 1);
    chk("timeout_busy", longint'(bus.busy), 0);
    chk("timeout_no_valid", longint'(bus.avg_valid), 0);
    chk("timeout_avg_kept", longint'(bus.bpm1_i_avg), 64);

    // Overrun is sticky across a completed average
    drv(1, 0, 1, 200, -200, 17, -17);
    cyc();
    bus.trig = 1'b0;
    repeat (3) cyc();
    bus.trig = 1'b1;
    cyc();
    chk("overrun_set", longint'(bus.overrun), 1);
    wait_evt(0, 20, "overrun_valid_seen");
    chk("overrun_avg", longint'(bus.bpm1_i_avg), 200);
    chk("overrun_sticky", longint'(bus.overrun), 1);

    // Reset mid-ACCUM, then a clean run
    drv(1, 0, 1, 300, -300, 7, -7);
    cyc();
    bus.trig = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_busy", longint'(bus.busy), 0);
    chk("midrst_avg", longint'(bus.bpm1_q_avg), 0);
    chk("midrst_overrun", longint'(bus.overrun), 0);
    rst = 1'b0;
    cyc();
    chk("midrst_no_valid", longint'(bus.avg_valid), 0);
    drv(1, 0, 1, 300, -300, 7, -7);
    cyc();
    wait_evt(0, 20, "postrst_valid_seen");
    chk("postrst_i1", longint'(bus.bpm1_i_avg), 300);
    chk("postrst_q2", longint'(bus.bpm2_q_avg), -7);

    // Randomized transactions checked by the model every cycle
    for (int tr = 0; tr < 40; tr++) begin
      int p;
      p = (tr % 5 == 4) ? 4 : 60;
      drv(1, int'($urandom_range(0, 6)), 0, rv(), rv(), rv(), rv());
      cyc();
      seen = 1'b0;
      for (int c = 0; c < 150 && !seen; c++) begin
        drv($urandom_range(0, 99) < 3, int'($urandom_range(0, 255)),
            $urandom_range(0, 99) < p, rv(), rv(), rv(), rv());
        cyc();
        seen = bus.avg_valid || bus.timeout;
      end
      chk("rand_txn_ended", longint'(seen), 1);
      drv(0, 0, 0, 0, 0, 0, 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
